// File: rtl/grf_bank.sv
// General register file with same-cycle write bypass and a pending-write
// scoreboard that flags reads of registers whose producer has not written back.
module grf_bank #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int TRACE  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] read_addr1,
   input  logic [ADDR_W-1:0] read_addr2,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   output logic              read_busy1,
   output logic              read_busy2,
   input  logic              write_en,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [DATA_W-1:0] write_data,
   input  logic [31:0]       write_pc,
   input  logic              issue_en,
   input  logic [ADDR_W-1:0] issue_addr,
   input  logic              flush,
   output logic [ADDR_W:0]   pending_cnt
);

   localparam int NREG = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_reg [NREG];
   logic [NREG-1:0]   pending_reg;
   logic [NREG-1:0]   pending_next;
   logic [ADDR_W:0]   pending_cnt_reg;
   logic [ADDR_W:0]   pending_cnt_next;
   logic              write_eff;

   assign write_eff = write_en && (write_addr != '0);

   genvar gi;
   generate
      for (gi = 0; gi < NREG; gi++) begin : g_reg
         // Entry 0 is never written, so it holds the hardwired zero.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               regs_reg[gi] <= '0;
            end else if (write_eff && (write_addr == ADDR_W'(gi))) begin
               regs_reg[gi] <= write_data;
            end
         end

         // Flush beats everything; a new issue beats a same-cycle writeback.
         assign pending_next[gi] = (gi != 0) && !flush &&
            ((issue_en && (issue_addr == ADDR_W'(gi))) ||
             (pending_reg[gi] && !(write_en && (write_addr == ADDR_W'(gi)))));
      end
   endgenerate

   always_comb begin
      pending_cnt_next = '0;
      for (int i = 0; i < NREG; i++) begin
         pending_cnt_next = pending_cnt_next + (ADDR_W+1)'(pending_next[i]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending_reg     <= '0;
         pending_cnt_reg <= '0;
      end else begin
         pending_reg     <= pending_next;
         pending_cnt_reg <= pending_cnt_next;
      end
   end

   assign pending_cnt = pending_cnt_reg;

   function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
      logic [DATA_W-1:0] value;
      value = regs_reg[addr];
      if (addr == '0) begin
         value = '0;
      end else if (write_en && (write_addr == addr)) begin
         value = write_data;
      end
      return value;
   endfunction

   always_comb begin
      read_data1 = read_port(read_addr1);
      read_data2 = read_port(read_addr2);
   end

   // A value arriving this cycle is usable, so it clears the stall at once.
   assign read_busy1 = (read_addr1 != '0) && pending_reg[read_addr1] &&
                       !(write_en && (write_addr == read_addr1));
   assign read_busy2 = (read_addr2 != '0) && pending_reg[read_addr2] &&
                       !(write_en && (write_addr == read_addr2));

`ifndef SYNTHESIS
   generate
      if (TRACE == 1) begin : g_trace
         always @(posedge clk) begin
            if (reset && write_eff) begin
               $display("@%h: $%d <= %h", write_pc, write_addr, write_data);
            end
         end
      end
   endgenerate
`endif

endmodule

// File: tb/tb_grf_bank.sv
// Directed bench for grf_bank: the driver queues expected values, a monitor
// process pops and compares them against the live outputs.
module tb_grf_bank;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  read_addr1, read_addr2;
   logic [31:0] read_data1, read_data2;
   logic        read_busy1, read_busy2;
   logic        write_en;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic [31:0] write_pc;
   logic        issue_en;
   logic [4:0]  issue_addr;
   logic        flush;
   logic [5:0]  pending_cnt;

   grf_bank #(.DATA_W(32), .ADDR_W(5), .TRACE(1)) dut (
      .clk         (clk),
      .reset       (reset),
      .read_addr1  (read_addr1),
      .read_addr2  (read_addr2),
      .read_data1  (read_data1),
      .read_data2  (read_data2),
      .read_busy1  (read_busy1),
      .read_busy2  (read_busy2),
      .write_en    (write_en),
      .write_addr  (write_addr),
      .write_data  (write_data),
      .write_pc    (write_pc),
      .issue_en    (issue_en),
      .issue_addr  (issue_addr),
      .flush       (flush),
      .pending_cnt (pending_cnt)
   );

   always #5 clk = ~clk;

   localparam int S_RD1 = 0, S_RD2 = 1, S_BUSY1 = 2, S_BUSY2 = 3, S_CNT = 4;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic check_req = 1'b0;

   function automatic logic [31:0] actual(input int sel);
      case (sel)
         S_RD1:   return read_data1;
         S_RD2:   return read_data2;
         S_BUSY1: return {31'b0, read_busy1};
         S_BUSY2: return {31'b0, read_busy2};
         default: return {26'b0, pending_cnt};
      endcase
   endfunction

   // Monitor: drains the scoreboard whenever the driver presents settled outputs.
   initial begin
      exp_t        e;
      logic [31:0] act;
      forever begin
         wait (check_req);
         while (sb.size() > 0) begin
            e   = sb.pop_front();
            act = actual(e.sel);
            checks++;
            if (act !== e.exp) begin
               errors++;
               $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
            end else begin
               $display("ok   %s: %h", e.name, act);
            end
         end
         check_req = 1'b0;
      end
   end

   task automatic expect_val(input string name, input int sel, input logic [31:0] v);
      sb.push_back('{name, sel, v});
   endtask

   task automatic run_checks();
      #1;
      check_req = 1'b1;
      wait (check_req == 1'b0);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      write_en = 0; write_addr = 0; write_data = 0; write_pc = 0;
      issue_en = 0; issue_addr = 0; flush = 0;
   endtask

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog: got timeout, expected finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      reset = 0; read_addr1 = 0; read_addr2 = 0;
      set_idle();
      cyc(); cyc();
      reset = 1;

      // Reset state on all addresses
      for (int a = 0; a < 32; a++) begin
         read_addr1 = 5'(a);
         read_addr2 = 5'(31 - a);
         expect_val($sformatf("reset_rd1_%0d", a), S_RD1, 32'h0);
         expect_val($sformatf("reset_rd2_%0d", 31 - a), S_RD2, 32'h0);
         expect_val($sformatf("reset_busy1_%0d", a), S_BUSY1, 32'h0);
         expect_val($sformatf("reset_busy2_%0d", 31 - a), S_BUSY2, 32'h0);
         run_checks();
      end
      expect_val("reset_cnt", S_CNT, 32'd0);
      run_checks();

      // Write $5 with bypass, then from the array
      write_en = 1; write_addr = 5; write_data = 32'h12345678; write_pc = 32'h3000;
      read_addr1 = 5; read_addr2 = 6;
      expect_val("bypass_rd1_5", S_RD1, 32'h12345678);
      expect_val("bypass_rd2_6", S_RD2, 32'h0);
      run_checks();
      cyc(); set_idle();
      expect_val("array_rd1_5", S_RD1, 32'h12345678);
      expect_val("array_rd2_6", S_RD2, 32'h0);
      run_checks();

      // Write to $0 is discarded, including on the bypass path
      write_en = 1; write_addr = 0; write_data = 32'hFFFFFFFF;
      read_addr1 = 0; read_addr2 = 5;
      expect_val("zero_bypass_rd1", S_RD1, 32'h0);
      expect_val("zero_cnt", S_CNT, 32'd0);
      run_checks();
      cyc(); set_idle();
      expect_val("zero_array_rd1", S_RD1, 32'h0);
      expect_val("zero_keeps_5", S_RD2, 32'h12345678);
      run_checks();

      // Issue $8, then write it back
      issue_en = 1; issue_addr = 8;
      cyc(); set_idle();
      read_addr2 = 8; read_addr1 = 8;
      expect_val("issue8_busy2", S_BUSY2, 32'h1);
      expect_val("issue8_busy1", S_BUSY1, 32'h1);
      expect_val("issue8_cnt", S_CNT, 32'd1);
      run_checks();
      write_en = 1; write_addr = 8; write_data = 32'hAAAA5555;
      expect_val("wb8_busy2_same_cycle", S_BUSY2, 32'h0);
      expect_val("wb8_rd2_bypass", S_RD2, 32'hAAAA5555);
      expect_val("wb8_cnt_before_edge", S_CNT, 32'd1);
      run_checks();
      cyc(); set_idle();
      expect_val("wb8_cnt_after", S_CNT, 32'd0);
      expect_val("wb8_busy2_after", S_BUSY2, 32'h0);
      expect_val("wb8_rd2_after", S_RD2, 32'hAAAA5555);
      run_checks();

      // Write and issue the same register in one cycle: set wins
      write_en = 1; write_addr = 8; write_data = 32'h0BADF00D;
      issue_en = 1; issue_addr = 8;
      cyc(); set_idle();
      expect_val("wi8_rd2", S_RD2, 32'h0BADF00D);
      expect_val("wi8_busy2", S_BUSY2, 32'h1);
      expect_val("wi8_cnt", S_CNT, 32'd1);
      run_checks();
      write_en = 1; write_addr = 8; write_data = 32'h00000011;
      cyc(); set_idle();
      expect_val("clear8_cnt", S_CNT, 32'd0);
      run_checks();

      // Issue to $0 never marks anything
      issue_en = 1; issue_addr = 0;
      cyc(); set_idle();
      read_addr1 = 0;
      expect_val("issue0_cnt", S_CNT, 32'd0);
      expect_val("issue0_busy1", S_BUSY1, 32'h0);
      run_checks();

      // Issue $3,$4,$5 plus a repeated $3
      issue_en = 1;
      issue_addr = 3; cyc();
      issue_addr = 4; cyc();
      issue_addr = 5; cyc();
      issue_addr = 3; cyc();
      set_idle();
      read_addr1 = 3; read_addr2 = 5;
      expect_val("multi_cnt", S_CNT, 32'd3);
      expect_val("multi_busy1_3", S_BUSY1, 32'h1);
      expect_val("multi_busy2_5", S_BUSY2, 32'h1);
      run_checks();

      // Flush with a concurrent issue and a write that must still land
      flush = 1; issue_en = 1; issue_addr = 6;
      write_en = 1; write_addr = 7; write_data = 32'h00000077;
      cyc(); set_idle();
      expect_val("flush_cnt", S_CNT, 32'd0);
      expect_val("flush_busy1_3", S_BUSY1, 32'h0);
      expect_val("flush_busy2_5", S_BUSY2, 32'h0);
      run_checks();
      read_addr1 = 6; read_addr2 = 7;
      expect_val("flush_busy1_6", S_BUSY1, 32'h0);
      expect_val("flush_rd2_7", S_RD2, 32'h00000077);
      run_checks();

      // Asynchronous reset mid-run, then a write held through reset is lost
      issue_en = 1; issue_addr = 9;
      cyc(); set_idle();
      expect_val("pre_reset_cnt", S_CNT, 32'd1);
      run_checks();
      #2;
      reset = 0;
      read_addr1 = 5; read_addr2 = 7;
      expect_val("async_cnt", S_CNT, 32'd0);
      expect_val("async_rd1_5", S_RD1, 32'h0);
      expect_val("async_rd2_7", S_RD2, 32'h0);
      run_checks();
      write_en = 1; write_addr = 10; write_data = 32'hDEADBEEF;
      cyc();
      set_idle();
      reset = 1;
      read_addr1 = 10; read_addr2 = 9;
      expect_val("reset_write_lost", S_RD1, 32'h0);
      expect_val("reset_busy2_9", S_BUSY2, 32'h0);
      run_checks();

      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
